// File: rtl/uart_row_reporter.sv
// uart_row_reporter: streams a header plus per-channel row dumps and status chars as ASCII
// bytes over a ready/valid interface. Define ROW_REPORT_HEX_EN to send rows as hex digits.
module uart_row_reporter #(
  parameter int ROW_W        = 141,
  parameter int NUM_ROWS     = 15,
  parameter int NUM_CH       = 4,
  parameter int HEADER_LEN   = 28,
  parameter int WAIT_TIMEOUT = 0,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ROW_AW      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trig,
  input  logic [8*HEADER_LEN-1:0] header,
  input  logic [NUM_CH-1:0]       src_ready,
  input  logic [NUM_CH-1:0]       src_done,
  output logic [CH_W-1:0]         row_ch,
  output logic [ROW_AW-1:0]       row_addr,
  input  logic [ROW_W-1:0]        row_data,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    frame_done
);

`ifdef ROW_REPORT_HEX_EN
  localparam int BUF_W     = ((ROW_W + 3) / 4) * 4;
  localparam int ROW_CHARS = BUF_W / 4;
  localparam int SHIFT     = 4;
`else
  localparam int BUF_W     = ROW_W;
  localparam int ROW_CHARS = ROW_W;
  localparam int SHIFT     = 1;
`endif
  localparam int MAX_CNT = (HEADER_LEN > ROW_CHARS) ? ((HEADER_LEN > 4) ? HEADER_LEN : 4)
                                                    : ((ROW_CHARS > 4) ? ROW_CHARS : 4);
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int WT_W    = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, HEADER, CH_WAIT, TAG, ROW_REQ, ROW_BUF, ROW_SEND, STATUS, NL, TMO
  } stateT;

  stateT             state, nextState;
  logic [CNT_W-1:0]  byteCnt;
  logic [BUF_W-1:0]  rowBuf;
  logic [WT_W-1:0]   waitCnt;
  logic              statusBit;
  logic [CH_W-1:0]   rowChQ;
  logic [ROW_AW-1:0] rowAddrQ;
  logic              frameDoneQ;
  logic [7:0]        txDataC;
  logic              txValidC;
  logic              accept;
  logic              lastCh;
  logic              lastRow;
  logic [7:0]        tagChar;

  function automatic logic [7:0] hexChar(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'd0, n} : 8'h37 + {4'd0, n};
  endfunction

  assign accept  = txValidC & tx_ready;
  assign lastCh  = (rowChQ == CH_W'(NUM_CH - 1));
  assign lastRow = (rowAddrQ == ROW_AW'(NUM_ROWS - 1));
  assign tagChar = hexChar(4'(rowChQ));

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    nextState = state;
    txValidC  = 1'b0;
    txDataC   = 8'h00;
    case (state)
      IDLE:    if (trig) nextState = HEADER;
      HEADER: begin
        txValidC = 1'b1;
        txDataC  = header[8 * (HEADER_LEN - 1 - int'(byteCnt)) +: 8];
        if (accept && byteCnt == CNT_W'(HEADER_LEN - 1)) nextState = CH_WAIT;
      end
      CH_WAIT: begin
        if (src_ready[rowChQ]) nextState = TAG;
        else if (WAIT_TIMEOUT != 0 && waitCnt == WT_W'(WAIT_TIMEOUT)) nextState = TMO;
      end
      TAG: begin
        txValidC = 1'b1;
        txDataC  = (byteCnt == '0) ? tagChar : 8'h3A;
        if (accept && byteCnt != '0) nextState = ROW_REQ;
      end
      ROW_REQ: nextState = ROW_BUF;
      ROW_BUF: nextState = ROW_SEND;
      ROW_SEND: begin
        txValidC = 1'b1;
`ifdef ROW_REPORT_HEX_EN
        txDataC  = hexChar(rowBuf[BUF_W-1 -: 4]);
`else
        txDataC  = rowBuf[BUF_W-1] ? 8'h31 : 8'h30;
`endif
        if (accept && byteCnt == CNT_W'(ROW_CHARS - 1)) nextState = lastRow ? STATUS : ROW_REQ;
      end
      STATUS: begin
        txValidC = 1'b1;
        txDataC  = statusBit ? 8'h31 : 8'h30;
        if (accept) nextState = NL;
      end
      NL: begin
        txValidC = 1'b1;
        txDataC  = 8'h0A;
        if (accept) nextState = lastCh ? IDLE : CH_WAIT;
      end
      TMO: begin
        txValidC = 1'b1;
        case (byteCnt)
          CNT_W'(0): txDataC = tagChar;
          CNT_W'(1): txDataC = 8'h3A;
          CNT_W'(2): txDataC = 8'h54;
          default:   txDataC = 8'h0A;
        endcase
        if (accept && byteCnt == CNT_W'(3)) nextState = lastCh ? IDLE : CH_WAIT;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      byteCnt    <= '0;
      rowBuf     <= '0;
      waitCnt    <= '0;
      statusBit  <= 1'b0;
      rowChQ     <= '0;
      rowAddrQ   <= '0;
      frameDoneQ <= 1'b0;
    end else begin
      state      <= nextState;
      frameDoneQ <= (nextState == IDLE) && (state != IDLE);

      if (nextState != state) byteCnt <= '0;
      else if (accept)        byteCnt <= byteCnt + CNT_W'(1);

      // Wait counter restarts on every CH_WAIT entry and sticks at its maximum.
      if (nextState == CH_WAIT && state != CH_WAIT) waitCnt <= '0;
      else if (state == CH_WAIT && waitCnt != '1)   waitCnt <= waitCnt + WT_W'(1);

      if (state == ROW_BUF)                rowBuf <= BUF_W'(row_data);
      else if (state == ROW_SEND && accept) rowBuf <= rowBuf << SHIFT;

      if (nextState == STATUS && state != STATUS) statusBit <= src_done[rowChQ];

      if ((state == NL || state == TMO) && nextState != state) begin
        rowChQ   <= lastCh ? '0 : rowChQ + CH_W'(1);
        rowAddrQ <= '0;
      end else if (state == ROW_SEND && nextState == ROW_REQ) begin
        rowAddrQ <= rowAddrQ + ROW_AW'(1);
      end
    end
  end

  assign row_ch     = rowChQ;
  assign row_addr   = rowAddrQ;
  assign tx_data    = txDataC;
  assign tx_valid   = txValidC;
  assign busy       = (state != IDLE);
  assign frame_done = frameDoneQ;

endmodule

// File: tb/tb_uart_row_reporter.sv
// Bench for uart_row_reporter: table of frame scenarios compared against a string-level model,
// plus hand sequences for re-trigger, mid-frame reset, late src_ready and timeout timing.
module tb_uart_row_reporter;
  localparam int ROW_W = 8, NUM_ROWS = 2, NUM_CH = 2, HEADER_LEN = 2;

  logic clk = 1'b0, reset = 1'b1, trig = 1'b0, txReady = 1'b1;
  logic [8*HEADER_LEN-1:0] header = "H:";
  logic [NUM_CH-1:0] srcReady = '0, srcDone = '0;
  logic [7:0] txData [2];
  logic txValid [2], busy [2], frameDone [2];
  logic [0:0] rowCh [2], rowAddr [2];
  logic [ROW_W-1:0] rowData [2];
  logic [ROW_W-1:0] mem [NUM_CH][NUM_ROWS];

  int checks = 0, errors = 0;
  logic [7:0] got[$], expQ[$];
  int acceptCycle[$];
  int doneCount, gotAtRaise;

  always #5 clk = ~clk;

  // Synchronous row RAM per instance: data follows the address by one cycle.
  always @(posedge clk) begin
    rowData[0] <= mem[rowCh[0]][rowAddr[0]];
    rowData[1] <= mem[rowCh[1]][rowAddr[1]];
  end

  uart_row_reporter #(.ROW_W(ROW_W), .NUM_ROWS(NUM_ROWS), .NUM_CH(NUM_CH),
                      .HEADER_LEN(HEADER_LEN), .WAIT_TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .trig(trig), .header(header), .src_ready(srcReady),
    .src_done(srcDone), .row_ch(rowCh[0]), .row_addr(rowAddr[0]), .row_data(rowData[0]),
    .tx_data(txData[0]), .tx_valid(txValid[0]), .tx_ready(txReady), .busy(busy[0]),
    .frame_done(frameDone[0]));

  uart_row_reporter #(.ROW_W(ROW_W), .NUM_ROWS(NUM_ROWS), .NUM_CH(NUM_CH),
                      .HEADER_LEN(HEADER_LEN), .WAIT_TIMEOUT(10)) dut1 (
    .clk(clk), .reset(reset), .trig(trig), .header(header), .src_ready(srcReady),
    .src_done(srcDone), .row_ch(rowCh[1]), .row_addr(rowAddr[1]), .row_data(rowData[1]),
    .tx_data(txData[1]), .tx_valid(txValid[1]), .tx_ready(txReady), .busy(busy[1]),
    .frame_done(frameDone[1]));

  typedef struct packed {
    logic [1:0]  ready;
    logic [1:0]  done;
    logic [31:0] rows;      // ch0r0, ch0r1, ch1r0, ch1r1 from MSB down
    bit          randReady;
    int          sel;       // 0: no timeout, 1: WAIT_TIMEOUT=10
    int          expLen;    // -1 when the vector is random
  } vecT;

  vecT vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame built as text straight from the frame format.
  function automatic void buildExpected(input vecT v);
    string s = "H:";
    for (int c = 0; c < NUM_CH; c++) begin
      string tag = $sformatf("%0X", c);
      if (!v.ready[c]) s = {s, tag, ":T\n"};
      else begin
        s = {s, tag, ":"};
        for (int r = 0; r < NUM_ROWS; r++) begin
          logic [7:0] row = v.rows[31 - 8 * (c * NUM_ROWS + r) -: 8];
`ifdef ROW_REPORT_HEX_EN
          s = {s, $sformatf("%02X", row)};
`else
          s = {s, $sformatf("%08b", row)};
`endif
        end
        s = {s, v.done[c] ? "1" : "0", "\n"};
      end
    end
    expQ.delete();
    for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
  endfunction

  task automatic loadVec(input vecT v);
    for (int c = 0; c < NUM_CH; c++)
      for (int r = 0; r < NUM_ROWS; r++) mem[c][r] = v.rows[31 - 8 * (c * NUM_ROWS + r) -: 8];
    srcDone = v.done;
    buildExpected(v);
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1; trig = 1'b0; txReady = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic runFrame(input int sel, input bit randReady, input int trigAt, input int resetAt,
                          input int readyDelay, input logic [1:0] readyVal);
    bit prevStall = 1'b0, trigFired = 1'b0, finished = 1'b0;
    logic [7:0] prevData = '0;
    int quiet = 0;
    got.delete(); acceptCycle.delete(); doneCount = 0; gotAtRaise = -1;
    applyReset();
    srcReady = (readyDelay > 0) ? 2'b00 : readyVal;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      @(negedge clk);
      trig = 1'b0;
      if (frameDone[sel]) begin
        doneCount++;
        finished = 1'b1;
      end else begin
        if (prevStall) check("stall hold", {txValid[sel], txData[sel]}, {1'b1, prevData});
        if (readyDelay > 0 && cyc == readyDelay) begin
          gotAtRaise = got.size();
          srcReady = readyVal;
        end
        if (resetAt >= 0 && got.size() == resetAt) begin
          reset = 1'b1; txReady = 1'b0;
          @(negedge clk);
          check("abort tx_valid", txValid[sel], 0);
          check("abort busy", busy[sel], 0);
          reset = 1'b0; txReady = 1'b1;
          repeat (30) begin
            @(negedge clk);
            if (frameDone[sel] || txValid[sel]) quiet++;
          end
          check("abort quiet", quiet, 0);
          return;
        end
        if (cyc == 0 || (trigAt >= 0 && got.size() == trigAt && !trigFired)) begin
          trig = 1'b1;
          trigFired = (cyc != 0);
        end
        txReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        if (txValid[sel] && txReady) begin
          got.push_back(txData[sel]);
          acceptCycle.push_back(cyc);
        end
        prevStall = txValid[sel] && !txReady;
        prevData  = txData[sel];
      end
    end
    check("frame end seen", finished, 1);
    txReady = 1'b1;
    @(negedge clk);
    check("frame_done width", frameDone[sel], 0);
  endtask

  task automatic compareFrame(input string name);
    int n = (got.size() < expQ.size()) ? got.size() : expQ.size();
    check({name, " len"}, got.size(), expQ.size());
    for (int i = 0; i < n; i++) check($sformatf("%s byte %0d", name, i), got[i], expQ[i]);
  endtask

  initial begin
    string lit;
    int quiet, tPos, gap;
`ifdef ROW_REPORT_HEX_EN
    lit = "H:0:A50F0\n1:80011\n";
    vecs[0] = '{2'b11, 2'b10, 32'hA50F8001, 1'b0, 0, 18};
    vecs[1] = '{2'b11, 2'b10, 32'hA50F8001, 1'b1, 0, 18};
    vecs[2] = '{2'b01, 2'b10, 32'hA50F8001, 1'b0, 1, 14};
    vecs[5] = '{2'b10, 2'b11, $urandom,     1'b0, 1, 14};
`else
    lit = {"H:0:1010010100001111", "0\n1:1000000000000001", "1\n"};
    vecs[0] = '{2'b11, 2'b10, 32'hA50F8001, 1'b0, 0, 42};
    vecs[1] = '{2'b11, 2'b10, 32'hA50F8001, 1'b1, 0, 42};
    vecs[2] = '{2'b01, 2'b10, 32'hA50F8001, 1'b0, 1, 26};
    vecs[5] = '{2'b10, 2'b11, $urandom,     1'b0, 1, 26};
`endif
    vecs[3] = '{2'b11, 2'($urandom), $urandom, 1'b1, 0, -1};
    vecs[4] = '{2'($urandom), 2'($urandom), $urandom, 1'b1, 1, -1};

    applyReset();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset tx_valid %0d", d), txValid[d], 0);
      check($sformatf("reset tx_data %0d", d), txData[d], 0);
      check($sformatf("reset busy %0d", d), busy[d], 0);
      check($sformatf("reset frame_done %0d", d), frameDone[d], 0);
      check($sformatf("reset row_ch %0d", d), {rowCh[d], rowAddr[d]}, 0);
    end

    reset = 1'b1; trig = 1'b1;
    @(negedge clk);
    reset = 1'b0; trig = 1'b0;
    @(negedge clk);
    check("trig under reset", busy[0], 0);

    foreach (vecs[k]) begin
      loadVec(vecs[k]);
      runFrame(vecs[k].sel, vecs[k].randReady, -1, -1, 0, vecs[k].ready);
      compareFrame($sformatf("vec%0d", k));
      check($sformatf("vec%0d frame_done count", k), doneCount, 1);
      if (vecs[k].expLen >= 0) check($sformatf("vec%0d length", k), got.size(), vecs[k].expLen);
      if (k == 0)
        for (int i = 0; i < lit.len(); i++) check($sformatf("literal byte %0d", i), got[i], lit[i]);
      if (vecs[k].sel == 1 && !vecs[k].randReady && vecs[k].ready != 2'b11) begin
        tPos = -1;
        foreach (expQ[i]) if (tPos < 0 && expQ[i] == "T") tPos = i;
        gap = acceptCycle[tPos - 2] - acceptCycle[tPos - 3];
        check($sformatf("vec%0d timeout gap in 10..13", k), (gap >= 10 && gap <= 13), 1);
      end
    end

    loadVec(vecs[0]);
    runFrame(0, 1'b0, 5, -1, 0, 2'b11);
    compareFrame("retrig");
    check("retrig frame_done count", doneCount, 1);
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (txValid[0] || busy[0]) quiet++;
    end
    check("retrig single frame", quiet, 0);

    runFrame(0, 1'b0, -1, 20, 0, 2'b11);
    for (int i = 0; i < 20; i++) check($sformatf("pre-abort byte %0d", i), got[i], expQ[i]);
    runFrame(0, 1'b1, -1, -1, 0, 2'b11);
    compareFrame("after abort");
    check("after abort frame_done count", doneCount, 1);

    runFrame(0, 1'b0, -1, -1, 50, 2'b11);
    compareFrame("late ready");
    check("late ready bytes before raise", gotAtRaise, 2);
    check("late ready tag cycle", acceptCycle[2], 51);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
